// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle load/store initiator between execute and a
// word-addressed data memory. One byte/half/word access per handshake;
// sub-word stores are read-modify-write; loads return extended data.
//
// Ports:
//   clk, reset                 rising-edge clock, async active-high reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_write/size/signed/addr/wdata   request payload (byte address)
//   resp_valid/rdata/err       one-cycle completion pulse and result
//   MemRead/MemWrite           memory enables (never both high)
//   ALUOut                     memory word index (req_addr >> 2)
//   reg2data                   memory write word
//   memout                     memory read data
module load_store_unit #(
    parameter int unsigned MEM_LAT   = 2,
    parameter int unsigned MEM_WORDS = 200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] ALUOut,
    output logic [31:0] reg2data,
    input  logic [31:0] memout
);

    localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [1:0]  SZ_BYTE = 2'b00;
    localparam logic [1:0]  SZ_HALF = 2'b01;
    localparam logic [1:0]  SZ_WORD = 2'b10;
    localparam logic [1:0]  SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR, RESP} state_t;

    // Request fields still needed after the accepting edge
    typedef struct packed {
        logic        write;
        logic [1:0]  size;
        logic        sgn;
        logic [1:0]  lane;
        logic [15:0] wdata;
    } req_t;

    state_t           state;
    req_t             req_q;
    logic [CNT_W-1:0] cnt;
    logic             req_err_c;

    assign req_ready = (state == IDLE) && !reset;

    // Misaligned, illegal-size or out-of-range request
    assign req_err_c = (req_size == SZ_ILL)
                    || ((req_size == SZ_HALF) && req_addr[0])
                    || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
                    || (32'(req_addr[31:2]) >= MEM_WORDS);

    // Right-justify the addressed byte/half and extend it
    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [1:0] lane, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{lane, 3'b000} +: 8];
        h = lane[1] ? w[31:16] : w[15:0];
        case (sz)
            SZ_BYTE: r = {{24{sgn & b[7]}}, b};
            SZ_HALF: r = {{16{sgn & h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    // Replace only the addressed lanes of the word read back from memory
    function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] sz,
                                          input logic [1:0] lane, input logic [15:0] wd);
        logic [31:0] r;
        r = w;
        if (sz == SZ_BYTE)
            r[{lane, 3'b000} +: 8] = wd[7:0];
        else if (lane[1])
            r[31:16] = wd;
        else
            r[15:0] = wd;
        return r;
    endfunction

    // Control FSM with registered memory and response outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            req_q      <= '0;
            cnt        <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            MemRead    <= 1'b0;
            MemWrite   <= 1'b0;
            ALUOut     <= '0;
            reg2data   <= '0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_q <= '{write: req_write, size: req_size, sgn: req_signed,
                                   lane: req_addr[1:0], wdata: req_wdata[15:0]};
                        if (req_err_c) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else if (req_write && (req_size == SZ_WORD)) begin
                            state    <= WR;
                            MemWrite <= 1'b1;
                            ALUOut   <= 32'(req_addr[31:2]);
                            reg2data <= req_wdata;
                        end else begin
                            state   <= RD_WAIT;
                            MemRead <= 1'b1;
                            ALUOut  <= 32'(req_addr[31:2]);
                            cnt     <= '0;
                        end
                    end
                end
                RD_WAIT: begin
                    if (cnt == CNT_W'(MEM_LAT - 1)) begin
                        MemRead <= 1'b0;
                        cnt     <= '0;
                        if (req_q.write) begin
                            state    <= WR;
                            MemWrite <= 1'b1;
                            reg2data <= merge(memout, req_q.size, req_q.lane, req_q.wdata);
                        end else begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b0;
                            resp_rdata <= extract(memout, req_q.size, req_q.lane, req_q.sgn);
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WR: begin
                    MemWrite   <= 1'b0;
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a word memory model and a
// scoreboard of expected responses.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] ALUOut;
    logic [31:0] reg2data;
    logic [31:0] memout;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] rd;
        logic        err;
    } exp_t;
    exp_t sb[$];

    logic [31:0] mem [0:255];
    logic        pre_we = 1'b0;
    logic [7:0]  pre_idx = 8'd0;
    logic [31:0] pre_data = 32'd0;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_LAT(2), .MEM_WORDS(200)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .MemRead(MemRead), .MemWrite(MemWrite),
        .ALUOut(ALUOut), .reg2data(reg2data), .memout(memout)
    );

    assign memout = mem[ALUOut[7:0]];

    always @(posedge clk) begin
        if (pre_we)
            mem[pre_idx] <= pre_data;
        else if (MemWrite)
            mem[ALUOut[7:0]] <= reg2data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [7:0] idx, input logic [31:0] data);
        @(negedge clk);
        pre_we   = 1'b1;
        pre_idx  = idx;
        pre_data = data;
        @(posedge clk);
        #1 pre_we = 1'b0;
    endtask

    // One access: drive, score, then watch memory/response per cycle
    task automatic do_req(input string tag, input logic wr, input logic [1:0] sz,
                          input logic sg, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                          input int exp_nrd, input int exp_nwr, input logic [31:0] exp_wword);
        int          got_lat;
        int          nrd;
        int          nwr;
        int          both;
        int          alu_ok;
        int          ready_resp;
        logic [31:0] wword;
        exp_t        e;
        got_lat = -1; nrd = 0; nwr = 0; both = 0; alu_ok = 1; ready_resp = -1;
        wword = 32'hx;
        @(negedge clk);
        chk({tag, ":ready_idle"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
        req_addr = addr; req_wdata = wd;
        sb.push_back('{rd: exp_rd, err: exp_err});
        // req_valid stays high through RESP; the unit must not re-accept
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (MemRead && MemWrite) both++;
            if (MemRead) nrd++;
            if (MemWrite) begin
                nwr++;
                wword = reg2data;
            end
            if ((MemRead || MemWrite) && (ALUOut !== (addr >> 2))) alu_ok = 0;
            if (resp_valid) begin
                got_lat = n;
                ready_resp = 32'(req_ready);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk({tag, ":rdata"}, resp_rdata, e.rd);
                    chk({tag, ":err"}, 32'(resp_err), 32'(e.err));
                end else begin
                    chk({tag, ":sb_empty"}, 32'd0, 32'd1);
                end
                break;
            end
        end
        chk({tag, ":latency"}, 32'(got_lat), 32'(exp_lat));
        chk({tag, ":n_read"}, 32'(nrd), 32'(exp_nrd));
        chk({tag, ":n_write"}, 32'(nwr), 32'(exp_nwr));
        chk({tag, ":rd_wr_overlap"}, 32'(both), 32'd0);
        chk({tag, ":aluout"}, 32'(alu_ok), 32'd1);
        chk({tag, ":ready_in_resp"}, 32'(ready_resp), 32'd0);
        if (exp_nwr > 0) chk({tag, ":wword"}, wword, exp_wword);
        @(negedge clk);
        chk({tag, ":resp_single"}, 32'(resp_valid), 32'd0);
        chk({tag, ":ready_after"}, 32'(req_ready), 32'd1);
        req_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h0;

        // Reset held with a pending request
        #7;
        chk("rst:ready", 32'(req_ready), 32'd0);
        chk("rst:resp_valid", 32'(resp_valid), 32'd0);
        chk("rst:resp_rdata", resp_rdata, 32'd0);
        chk("rst:resp_err", 32'(resp_err), 32'd0);
        chk("rst:memread", 32'(MemRead), 32'd0);
        chk("rst:memwrite", 32'(MemWrite), 32'd0);
        chk("rst:aluout", ALUOut, 32'd0);
        chk("rst:reg2data", reg2data, 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("rst:ready_release", 32'(req_ready), 32'd1);

        // Word store and word load
        do_req("sw", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 0, 1, 32'hDEADBEEF);
        chk("sw:mem", mem[4], 32'hDEADBEEF);
        do_req("lw", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 3, 2, 0, 32'h0);

        // Sub-word stores (read-modify-write)
        preload(8'd4, 32'h11223344);
        do_req("sb3", 1'b1, 2'b00, 1'b0, 32'h13, 32'hAAAAAA55, 32'h0, 1'b0, 4, 2, 1, 32'h55223344);
        do_req("sh2", 1'b1, 2'b01, 1'b0, 32'h12, 32'h1234BEEF, 32'h0, 1'b0, 4, 2, 1, 32'hBEEF3344);
        do_req("sb0", 1'b1, 2'b00, 1'b0, 32'h10, 32'hFFFFFF99, 32'h0, 1'b0, 4, 2, 1, 32'hBEEF3399);
        do_req("lw_rmw", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hBEEF3399, 1'b0, 3, 2, 0, 32'h0);

        // Sub-word loads with extension
        preload(8'd4, 32'h00800000);
        do_req("lb_s", 1'b0, 2'b00, 1'b1, 32'h12, 32'h0, 32'hFFFFFF80, 1'b0, 3, 2, 0, 32'h0);
        do_req("lb_u", 1'b0, 2'b00, 1'b0, 32'h12, 32'h0, 32'h00000080, 1'b0, 3, 2, 0, 32'h0);
        do_req("lh_u", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'h00000080, 1'b0, 3, 2, 0, 32'h0);
        preload(8'd4, 32'h80017FFE);
        do_req("lh_s_hi", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'hFFFF8001, 1'b0, 3, 2, 0, 32'h0);
        do_req("lh_s_lo", 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 32'h00007FFE, 1'b0, 3, 2, 0, 32'h0);

        // Last valid word and error cases
        preload(8'd199, 32'hCAFEF00D);
        do_req("lw_last", 1'b0, 2'b10, 1'b0, 32'h31C, 32'h0, 32'hCAFEF00D, 1'b0, 3, 2, 0, 32'h0);
        do_req("err_half", 1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 32'h0, 1'b1, 1, 0, 0, 32'h0);
        do_req("err_range", 1'b0, 2'b10, 1'b0, 32'h322, 32'h0, 32'h0, 1'b1, 1, 0, 0, 32'h0);
        do_req("err_range_al", 1'b0, 2'b10, 1'b0, 32'h320, 32'h0, 32'h0, 1'b1, 1, 0, 0, 32'h0);
        do_req("err_size", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 1, 0, 0, 32'h0);
        do_req("err_word_mis", 1'b1, 2'b10, 1'b0, 32'h12, 32'h1, 32'h0, 1'b1, 1, 0, 0, 32'h0);
        do_req("err_sb_range", 1'b1, 2'b00, 1'b0, 32'h320, 32'h1, 32'h0, 1'b1, 1, 0, 0, 32'h0);

        // Reset in the middle of a load drops it without a response
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 32'h10;
        @(negedge clk);
        req_valid = 1'b0;
        chk("mid:memread_before", 32'(MemRead), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid:memread_async", 32'(MemRead), 32'd0);
        chk("mid:aluout_async", ALUOut, 32'd0);
        chk("mid:ready_in_reset", 32'(req_ready), 32'd0);
        begin
            int stray;
            stray = 0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (i == 1) reset = 1'b0;
                if (resp_valid) stray++;
            end
            chk("mid:no_resp", 32'(stray), 32'd0);
        end
        do_req("post_rst_lw", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h80017FFE, 1'b0, 3, 2, 0, 32'h0);

        chk("sb:drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store initiator between the execute stage and the word-addressed data memory. It accepts one byte, half-word or word access per handshake and drives the memory's MemRead/MemWrite/ALUOut/reg2data port, waiting a fixed read latency. Sub-word stores are done as read-modify-write. It returns sign- or zero-extended load data, or flags an error for misaligned or out-of-range accesses.

## Interface
Parameters:
- MEM_LAT, 2: cycles MemRead is held before memout is sampled; must be at least 1.
- MEM_WORDS, 200: number of 32-bit words in data memory; word indices at or above this value are out of range.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal
- req_signed  in  1  sign-extend loads (ignored for stores and word loads)
- req_addr  in  32  byte address
- req_wdata  in  32  store data; the sub-word value is in the low bits
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  qualified by resp_valid
- MemRead  out  1  memory read enable
- MemWrite  out  1  memory write enable (word-wide, sampled by memory on posedge)
- ALUOut  out  32  word index = req_addr >> 2
- reg2data  out  32  full write word
- memout  in  32  memory read data

## Operation
- States: IDLE, RD_WAIT, WR, RESP.
- **IDLE**
  - req_ready = 1 (forced 0 while reset is high).
  - On req_valid && req_ready, capture all request fields at the edge. Then:
    - Error → RESP with err = 1 and no memory access. Error is any of: size 11; half with addr[0] = 1; word with addr[1:0] ≠ 0; addr[31:2] ≥ MEM_WORDS.
    - Word store → WR.
    - Any load or sub-word store → RD_WAIT.
- **RD_WAIT**
  - MemRead = 1 and ALUOut = word index, held constant.
  - Counter runs 0..MEM_LAT-1; memout is sampled on the edge ending count MEM_LAT-1.
  - Load → RESP with extracted data. Sub-word store → merge, then WR.
- **WR**
  - MemWrite = 1 for exactly one cycle; reg2data = final word; ALUOut = word index.
  - Next state RESP.
- **RESP**
  - resp_valid = 1 for exactly one cycle; req_ready = 0.
  - Next state IDLE. The response cannot be back-pressured.
- **Byte lanes:** little-endian; byte k = bits [8k+7:8k], with k = addr[1:0]. Half = lanes {addr[1],0} and {addr[1],1}.
- **Load extraction:** the selected byte/half is right-justified. Upper bits are copies of its MSB if req_signed, else zero.
- **Store merge:**
  - Only the addressed lanes are replaced, by req_wdata[7:0] or [15:0].
  - Other lanes keep the sampled memout value.
  - Word store: reg2data = req_wdata.
- MemRead and MemWrite are never high in the same cycle. Both are 0 in IDLE and RESP.
- ALUOut and reg2data hold their last value outside memory states (don't-care to the memory).

## Timing
- Cycle n is counted from the accepting edge (n = 0).
- resp_valid is high in cycle:
  - word store: 2
  - load: MEM_LAT+1
  - sub-word store: MEM_LAT+2
  - error: 1
- Next request can be accepted at the edge ending the RESP cycle + 1 (IDLE cycle). Throughput is one access per response + 1 cycle.
- **Reset values** (asserted at any time, effective immediately): state IDLE; counter 0; resp_valid 0; resp_rdata 0; resp_err 0; MemRead 0; MemWrite 0; ALUOut 0; reg2data 0.
- **Reset mid-operation:** the in-flight access is dropped with no response.
  - If reset lands during WR, MemWrite falls asynchronously; whether the memory commits depends on the edge ordering and is not guaranteed.
- **Back-to-back requests:** req_valid held high through RESP is not accepted until IDLE.

## Test plan
- Reset with req_valid = 1 → req_ready = 0 and all outputs 0; after release, req_ready = 1 next cycle.
- Word store 0x0000_0010 ← 0xDEADBEEF → ALUOut = 4, MemWrite high in cycle 1 only, resp_valid in cycle 2 with err = 0.
- Word load at 0x10 with memout = 0xDEADBEEF and MEM_LAT = 2 → MemRead high in cycles 1–2, resp_rdata = 0xDEADBEEF in cycle 3.
- Byte store 0x13 ← 0x55 with memout = 0x11223344 → one read, then reg2data = 0x55223344, then response (cycle 4).
- Signed byte load 0x12 with memout = 0x0080_0000 → 0xFFFFFF80; unsigned half load at 0x12 → 0x00000080.
- Error cases, each → resp_err = 1 in cycle 1 with MemRead and MemWrite never asserted:
  - half load at 0x11
  - word load at 0x322 (index 200)
  - req_size = 11
